// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit (LSB stage first).
// A single global stall holds every stage while the output beat waits for downstream.
`timescale 1ns/1ps

module barrel_shifter_pipe #(
  parameter  int DATA_W = 16,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic              out_bad_op
);

  typedef enum logic [2:0] {
    OP_ROR = 3'b000,
    OP_ROL = 3'b001,
    OP_LSR = 3'b010,
    OP_LSL = 3'b011,
    OP_ASR = 3'b100
  } op_e;

  if ((DATA_W < 4) || (DATA_W > 64) || ((DATA_W & (DATA_W - 1)) != 0)) begin : g_bad_param
    $error("barrel_shifter_pipe: DATA_W must be a power of two in 4..64");
  end

  // One stage's worth of work: shift or rotate by a fixed step s (0 < s < DATA_W).
  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] d,
                                                input logic [2:0]        op,
                                                input int unsigned       s);
    logic [DATA_W-1:0] r;
    r = d;
    case (op)
      OP_ROR:  r = (d >> s) | (d << (DATA_W - s));
      OP_ROL:  r = (d << s) | (d >> (DATA_W - s));
      OP_LSR:  r = d >> s;
      OP_LSL:  r = d << s;
      OP_ASR:  r = $unsigned($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  logic w_stall;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int unsigned STEP = 1 << k;

    logic [DATA_W-1:0]  w_data_in;
    logic               w_valid_in;
    logic               w_bad_in;
    logic [2:0]         w_op_in;
    logic [AMT_W-1-k:0] w_amt_in;

    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_bad;

    if (k == 0) begin : g_head
      assign w_data_in  = in_data;
      assign w_valid_in = in_valid;
      assign w_bad_in   = (in_op > OP_ASR);
      assign w_op_in    = in_op;
      assign w_amt_in   = in_amt;
    end else begin : g_link
      assign w_data_in  = g_stage[k-1].r_data;
      assign w_valid_in = g_stage[k-1].r_valid;
      assign w_bad_in   = g_stage[k-1].r_bad;
      assign w_op_in    = g_stage[k-1].g_fwd.r_op;
      assign w_amt_in   = g_stage[k-1].g_fwd.r_amt;
    end

    // NOTE: data is reset too, so out_data reads 0 and out_zero reads 1 while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_bad   <= 1'b0;
      end else if (!w_stall) begin
        r_valid <= w_valid_in;
        r_data  <= w_amt_in[0] ? f_shift(w_data_in, w_op_in, STEP) : w_data_in;
        r_bad   <= w_bad_in;
      end
    end

    // Op and the unconsumed amount bits only travel as far as a later stage needs them.
    if (k < AMT_W - 1) begin : g_fwd
      logic [2:0]         r_op;
      logic [AMT_W-2-k:0] r_amt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_op  <= '0;
          r_amt <= '0;
        end else if (!w_stall) begin
          r_op  <= w_op_in;
          r_amt <= w_amt_in[AMT_W-1-k:1];
        end
      end
    end
  end

  assign out_valid  = g_stage[AMT_W-1].r_valid;
  assign out_data   = g_stage[AMT_W-1].r_data;
  assign out_bad_op = g_stage[AMT_W-1].r_bad;
  assign out_zero   = (g_stage[AMT_W-1].r_data == '0);

  // Bubbles are never squeezed out, so a held output freezes the whole pipe.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (DATA_W = 16, four stages).
// The driver pushes model results on acceptance; an independent monitor pops on each consumed output.
`timescale 1ns/1ps

module tb_barrel_shifter_pipe;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LAT = 4;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_zero;
  logic          out_bad_op;

  barrel_shifter_pipe #(.DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_bad_op (out_bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          bad;
    int            acc_cyc;
    int            stall_snap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;
  int   ready_mode = 0;   // 0: high, 1: random, 2: low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: each output bit is picked straight from the operand by op rule.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                          input logic [2:0] op);
    logic [DW-1:0] r;
    int amt;
    amt = int'(a);
    for (int i = 0; i < DW; i++) begin
      case (op)
        3'd0:    r[i] = d[(i + amt) % DW];
        3'd1:    r[i] = d[(i - amt + DW) % DW];
        3'd2:    r[i] = (i + amt < DW) ? d[i + amt] : 1'b0;
        3'd3:    r[i] = (i >= amt) ? d[i - amt] : 1'b0;
        3'd4:    r[i] = (i + amt < DW) ? d[i + amt] : d[DW-1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Cycle and stall bookkeeping; values read here are the pre-edge ones.
  always @(posedge clk) begin
    if (out_valid && !out_ready) stall_cnt++;
    cyc++;
  end

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_bad;
  logic          prev_zero;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
        check("stall_bad", out_bad_op, prev_bad);
        check("stall_zero", out_zero, prev_zero);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_data, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_bad_op", out_bad_op, e.bad);
          check("out_zero", out_zero, (e.data == '0));
          check("latency", cyc - e.acc_cyc, LAT + (stall_cnt - e.stall_snap));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bad   = out_bad_op;
      prev_zero  = out_zero;
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1 after the accepting edge.
  task automatic send_x(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [2:0] op,
                        input logic [DW-1:0] req);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data       = req;
        e.bad        = (op > 3'd4);
        e.acc_cyc    = cyc;
        e.stall_snap = stall_cnt;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [2:0] op);
    send_x(d, a, op, model(d, a, op));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    bit seen;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_amt   = '0;
    in_op    = '0;

    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_zero", out_zero, 1'b1);
    check("rst_out_bad_op", out_bad_op, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    #19 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Rotates and shifts with known answers
    send_x(16'h8001, 4'd1, 3'b000, 16'hC000);
    send_x(16'h1234, 4'd4, 3'b001, 16'h2341);
    send_x(16'h1234, 4'd4, 3'b011, 16'h2340);
    send_x(16'h8000, 4'd15, 3'b010, 16'h0001);
    send_x(16'h8000, 4'd15, 3'b100, 16'hFFFF);
    send_x(16'h0001, 4'd1, 3'b010, 16'h0000);
    for (int op = 0; op < 5; op++) send_x(16'hA5C3, 4'd0, 3'(op), 16'hA5C3);
    // Reserved op then a normal beat
    send_x(16'hBEEF, 4'd5, 3'b110, 16'hBEEF);
    send_x(16'h00F0, 4'd4, 3'b011, 16'h0F00);
    drain();

    // Backpressure: six back-to-back beats, output held off for three cycles
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(16'h1111 * (i + 1)), 4'(i + 2), 3'(i % 5));
        in_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(posedge clk);
          #1;
          seen = out_valid;
        end
        check("bp_first_out", seen, 1'b1);
        ready_mode = 2;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 1'b0);
          @(posedge clk);
          #1;
        end
        ready_mode = 0;
      end
    join
    drain();

    // Throughput: 32 beats must be accepted in 32 cycles with output always ready
    t0 = cyc;
    for (int i = 0; i < 32; i++) send($urandom_range(0, 16'hFFFF), $urandom_range(0, 15), $urandom_range(0, 4));
    check("throughput_cycles", cyc - t0, 32);
    drain();

    // Reset with three beats in flight
    send(16'h1357, 4'd3, 3'b000);
    send(16'h2468, 4'd5, 3'b011);
    send(16'hFFFF, 4'd7, 3'b010);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 16'h0000);
    check("midrst_out_zero", out_zero, 1'b1);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(8);
    check("post_rst_quiet", out_valid, 1'b0);
    send_x(16'h0001, 4'd1, 3'b000, 16'h8000);
    drain();

    // Random stream with bubbles and random output backpressure
    ready_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send($urandom_range(0, 16'hFFFF), $urandom_range(0, 15), $urandom_range(0, 7));
    end
    ready_mode = 0;
    drain();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
